single_to_int_arbiter: RTL and testbench
========================================

# single_to_int_arbiter

Round-robin arbiter that shares one float-to-int converter (`single_to_int_small` or any block with the same ready/cont handshake) between NREQ independent requesters. The arbiter accepts one IEEE-754 single operand from one requester, drives it into the converter, and collects the integer result. It then returns the result to the same requester before it grants again. It sits between the converter instance and the client blocks in the numtype utility layer.

## Interface
- NREQ, 4: number of requesters, 2..8.
- GW, 3: grant index width, ≥ clog2(NREQ).
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_val  in  NREQ*32  operand of requester i in bits [32i+31:32i].
- in_cont  in  NREQ  requester i has an operand pending.
- in_ready  out  NREQ  one-hot; arbiter accepts operand of i.
- out_val  out  32  result for the current grantee.
- out_ready  out  NREQ  one-hot; result valid for requester i.
- out_cont  in  NREQ  requester i takes its result.
- cv_single_val  out  32  operand to converter.
- cv_single_cont  out  1  operand offered to converter.
- cv_single_ready  in  1  converter can take an operand.
- cv_int_val  in  32  converter result.
- cv_int_ready  in  1  converter result valid.
- cv_int_cont  out  1  arbiter takes the converter result.
- grant  out  GW  index of the current or last grantee.
- busy  out  1  high in every state except IDLE.

## Operation
- Transfer rule on every interface: data moves on a cycle where ready and cont are both high at the same posedge.
- FSM states and transitions:
  - IDLE: if any in_cont bit is high, register `grant` = first set bit searching from ptr+1 upward (mod NREQ), then go to ACCEPT.
  - ACCEPT: in_ready[grant]=1.
    - On transfer: capture in_val slice into op_r, go to ISSUE.
    - If in_cont[grant] is low: go back to IDLE, ptr unchanged (withdrawal).
  - ISSUE: cv_single_val=op_r, cv_single_cont=1. On cv_single_ready&&cv_single_cont, go to WAIT.
  - WAIT: cv_int_cont=1. On cv_int_ready, capture cv_int_val into res_r, go to DELIVER.
  - DELIVER: out_val=res_r, out_ready[grant]=1. On out_cont[grant], set ptr=grant and go to IDLE.
- Only one operation is in flight. Requests from other requesters are held off, with in_ready low, until the arbiter is back in IDLE.
- The pointer updates only when a delivery completes. A requester that withdraws in ACCEPT does not lose its priority turn.
- Data is passed bit-exact with no arithmetic. Overflow and special cases are the converter's job (for example, 0x80000000 for an out-of-range input).
- All outputs are registered. in_ready, out_ready, cv_single_cont and cv_int_cont are decoded from the registered state and grant only, with no input-to-output combinational paths.
- Reset:
  - Values: state=IDLE, ptr=NREQ-1 (so requester 0 wins first), grant=0, op_r=0, res_r=0, all outputs 0.
  - Reset in mid-operation abandons the transaction.
  - The converter must be reset in the same cycle, so the system must drive both resets from a common source.

## Timing
- Arbitration takes 1 cycle (IDLE to ACCEPT). Acceptance takes ≥1 cycle, and issue takes ≥1 cycle while the arbiter waits for cv_single_ready.
- The converter's own latency adds to the total. Delivery takes ≥1 cycle.
- Minimum overhead per request is 4 arbiter cycles plus converter latency.
- in_ready[grant] is high from the cycle after the grant registers until the transfer edge. It is low the cycle after the transfer.
- Simultaneous requests: with the pointer at p, requester (p+1)%NREQ has the highest priority. Back-to-back service of all NREQ requesters gives order p+1, p+2, … with no starvation.
- If out_cont is held low, the arbiter holds DELIVER indefinitely. out_val and out_ready stay stable, and no new grant is made.
- If in_cont[j] rises in the same cycle the arbiter enters IDLE, j takes part in that cycle's arbitration.

## Structure
- The shared package `numtype_pkg` holds:
  - state encoding localparams IDLE=0, ACCEPT=1, ISSUE=2, WAIT=3, DELIVER=4 (3 bits);
  - the SINGLE_W=32 and INT_W=32 constants.
- Sub-module `rr_pick`: a purely combinational round-robin picker. Inputs are req[NREQ] and ptr[GW]. Outputs are idx[GW] and any. The arbiter registers its output.
- The converter is not instantiated inside this block. The parent instantiates it and wires it to the cv_* ports.

## Test plan
- Single request: r0 sends 0x3F800000. out_val=0x00000001, out_ready=4'b0001, then the arbiter returns to IDLE with busy low.
- Simultaneous requests: all four in_cont high after reset, with 0xC0200000 on r2. Grants are served in order 0,1,2,3, and r2 receives 0xFFFFFFFE.
- Fairness: ptr=1 and r0 and r3 both request. r3 is served first, then r0.
- Backpressure on both sides:
  - cv_single_ready held low 10 cycles: the arbiter stays in ISSUE with cv_single_val stable.
  - out_cont held low 20 cycles: out_val stays stable and no new in_ready appears.
- Withdrawal: r1 drops in_cont during ACCEPT. The arbiter goes to IDLE, ptr is unchanged, and r1's next request wins ahead of lower-priority requesters.
- Reset in WAIT: rst is asserted asynchronously. All outputs are 0 within the same cycle, the next grant goes to requester 0, and 0x4F000000 then returns 0x80000000.

Source files
------------

// File: rtl/numtype_pkg.sv
// Shared numeric-type constants and the converter arbiter's state encoding.
package numtype_pkg;

    localparam int unsigned SINGLE_W = 32;
    localparam int unsigned INT_W    = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        DELIVER = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned GW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   idx,
    output logic            any
);

    logic        found;
    int unsigned cand;

    always_comb begin
        idx   = '0;
        any   = 1'b0;
        found = 1'b0;
        cand  = 0;
        // Offset 1 is highest priority, offset NREQ (ptr itself) is lowest.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && cand == i && req[i]) begin
                    idx   = GW'(i);
                    found = 1'b1;
                end
            end
        end
        any = found;
    end

endmodule

// File: rtl/single_to_int_arbiter.sv
// Round-robin arbiter sharing one float-to-int converter among NREQ requesters,
// one operation in flight at a time, result returned to the requester that issued it.
module single_to_int_arbiter
    import numtype_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned GW   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ*SINGLE_W-1:0] in_val,
    input  logic [NREQ-1:0]          in_cont,
    output logic [NREQ-1:0]          in_ready,
    output logic [INT_W-1:0]         out_val,
    output logic [NREQ-1:0]          out_ready,
    input  logic [NREQ-1:0]          out_cont,
    output logic [SINGLE_W-1:0]      cv_single_val,
    output logic                     cv_single_cont,
    input  logic                     cv_single_ready,
    input  logic [INT_W-1:0]         cv_int_val,
    input  logic                     cv_int_ready,
    output logic                     cv_int_cont,
    output logic [GW-1:0]            grant,
    output logic                     busy
);

    arb_state_t            state_r, state_n;
    logic [GW-1:0]         ptr_r, ptr_n;
    logic [GW-1:0]         grant_r, grant_n;
    logic [SINGLE_W-1:0]   op_r, op_n;
    logic [INT_W-1:0]      res_r, res_n;
    logic [NREQ-1:0]       in_ready_n, out_ready_n;
    logic                  cv_single_cont_n, cv_int_cont_n, busy_n;
    logic [GW-1:0]         pick_idx;
    logic                  pick_any;
    logic [SINGLE_W-1:0]   op_sel;
    logic                  in_cont_sel, out_cont_sel;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req (in_cont),
        .ptr (ptr_r),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Per-grantee views of the requester-side inputs.
    always_comb begin
        op_sel       = '0;
        in_cont_sel  = 1'b0;
        out_cont_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_r == GW'(i)) begin
                op_sel       = in_val[i*SINGLE_W +: SINGLE_W];
                in_cont_sel  = in_cont[i];
                out_cont_sel = out_cont[i];
            end
        end
    end

    // Next-state logic; handshake outputs are decoded from next state so they register with it.
    always_comb begin
        state_n          = state_r;
        ptr_n            = ptr_r;
        grant_n          = grant_r;
        op_n             = op_r;
        res_n            = res_r;
        in_ready_n       = '0;
        out_ready_n      = '0;
        cv_single_cont_n = 1'b0;
        cv_int_cont_n    = 1'b0;
        busy_n           = 1'b0;

        unique case (state_r)
            IDLE: begin
                if (pick_any) begin
                    grant_n = pick_idx;
                    state_n = ACCEPT;
                end
            end
            ACCEPT: begin
                // in_ready[grant] is high throughout ACCEPT, so in_cont alone decides.
                if (in_cont_sel) begin
                    op_n    = op_sel;
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (cv_single_ready) state_n = WAIT;
            end
            WAIT: begin
                if (cv_int_ready) begin
                    res_n   = cv_int_val;
                    state_n = DELIVER;
                end
            end
            DELIVER: begin
                if (out_cont_sel) begin
                    ptr_n   = grant_r;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        for (int unsigned i = 0; i < NREQ; i++) begin
            in_ready_n[i]  = (state_n == ACCEPT)  && (grant_n == GW'(i));
            out_ready_n[i] = (state_n == DELIVER) && (grant_n == GW'(i));
        end
        cv_single_cont_n = (state_n == ISSUE);
        cv_int_cont_n    = (state_n == WAIT);
        busy_n           = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            ptr_r          <= GW'(NREQ - 1);
            grant_r        <= '0;
            op_r           <= '0;
            res_r          <= '0;
            in_ready       <= '0;
            out_ready      <= '0;
            cv_single_cont <= 1'b0;
            cv_int_cont    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_r        <= state_n;
            ptr_r          <= ptr_n;
            grant_r        <= grant_n;
            op_r           <= op_n;
            res_r          <= res_n;
            in_ready       <= in_ready_n;
            out_ready      <= out_ready_n;
            cv_single_cont <= cv_single_cont_n;
            cv_int_cont    <= cv_int_cont_n;
            busy           <= busy_n;
        end
    end

    assign out_val       = res_r;
    assign cv_single_val = op_r;
    assign grant         = grant_r;

endmodule

// File: tb/tb_single_to_int_arbiter.sv
// Directed bench for single_to_int_arbiter; the bench plays the converter and all four requesters.
module tb_single_to_int_arbiter;

    logic         clk;
    logic         rst;
    logic [127:0] in_val;
    logic [3:0]   in_cont;
    logic [3:0]   in_ready;
    logic [31:0]  out_val;
    logic [3:0]   out_ready;
    logic [3:0]   out_cont;
    logic [31:0]  cv_single_val;
    logic         cv_single_cont;
    logic         cv_single_ready;
    logic [31:0]  cv_int_val;
    logic         cv_int_ready;
    logic         cv_int_cont;
    logic [2:0]   grant;
    logic         busy;

    logic [31:0]  vals [4];
    int           total = 0;
    int           bad   = 0;

    assign in_val = {vals[3], vals[2], vals[1], vals[0]};

    single_to_int_arbiter #(
        .NREQ (4),
        .GW   (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_val          (in_val),
        .in_cont         (in_cont),
        .in_ready        (in_ready),
        .out_val         (out_val),
        .out_ready       (out_ready),
        .out_cont        (out_cont),
        .cv_single_val   (cv_single_val),
        .cv_single_cont  (cv_single_cont),
        .cv_single_ready (cv_single_ready),
        .cv_int_val      (cv_int_val),
        .cv_int_ready    (cv_int_ready),
        .cv_int_cont     (cv_int_cont),
        .grant           (grant),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Truncating single-to-int converter behaviour, used only to drive cv_int_val.
    function automatic logic [31:0] f2i(input logic [31:0] f);
        int          e;
        logic [31:0] m;
        e = int'(f[30:23]) - 127;
        if (e < 0) return 32'h0;
        if (e >= 31) return 32'h8000_0000;
        m = {8'd1, f[22:0]};
        m = (e >= 23) ? (m << (e - 23)) : (m >> (23 - e));
        return f[31] ? -m : m;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
        chk({tag, "_out_ready"}, 32'(out_ready), 32'h0);
        chk({tag, "_out_val"}, out_val, 32'h0);
        chk({tag, "_cv_val"}, cv_single_val, 32'h0);
        chk({tag, "_cv_cont"}, 32'(cv_single_cont), 32'h0);
        chk({tag, "_int_cont"}, 32'(cv_int_cont), 32'h0);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
    endtask

    // Bounded wait, at negedges, for in_ready to show exactly requester r.
    task automatic wait_accept(input logic [1:0] r);
        logic [3:0] oh;
        int         n;
        oh = 4'b0001 << r;
        n  = 0;
        while (in_ready !== oh && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'(oh));
        chk("accept_grant", 32'(grant), 32'(r));
    endtask

    // Carries one already-requesting requester r through accept/issue/wait/deliver.
    task automatic run_txn(input logic [1:0] r, input logic [31:0] op,
                           input logic [31:0] exp_res, input int ih, input int dh);
        logic [3:0] oh;
        oh = 4'b0001 << r;
        wait_accept(r);
        @(negedge clk);
        chk("issue_cont", 32'(cv_single_cont), 32'h1);
        chk("issue_val", cv_single_val, op);
        chk("issue_in_ready_low", 32'(in_ready), 32'h0);
        in_cont = in_cont & ~oh;
        if (ih > 0) begin
            cv_single_ready = 1'b0;
            repeat (ih) begin
                @(negedge clk);
                chk("issue_hold_val", cv_single_val, op);
                chk("issue_hold_cont", 32'(cv_single_cont), 32'h1);
            end
            cv_single_ready = 1'b1;
        end
        @(negedge clk);
        chk("wait_cont", 32'(cv_int_cont), 32'h1);
        chk("wait_single_cont", 32'(cv_single_cont), 32'h0);
        cv_int_val   = f2i(op);
        cv_int_ready = 1'b1;
        @(negedge clk);
        cv_int_ready = 1'b0;
        cv_int_val   = 32'h0;
        chk("deliver_ready", 32'(out_ready), 32'(oh));
        chk("deliver_val", out_val, exp_res);
        chk("deliver_int_cont", 32'(cv_int_cont), 32'h0);
        repeat (dh) begin
            @(negedge clk);
            chk("deliver_hold_val", out_val, exp_res);
            chk("deliver_hold_ready", 32'(out_ready), 32'(oh));
            chk("deliver_hold_in_ready", 32'(in_ready), 32'h0);
        end
        out_cont = oh;
        @(negedge clk);
        out_cont = 4'b0000;
        chk("done_out_ready", 32'(out_ready), 32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        in_cont         = 4'b0000;
        out_cont        = 4'b0000;
        cv_single_ready = 1'b1;
        cv_int_val      = 32'h0;
        cv_int_ready    = 1'b0;
        for (int i = 0; i < 4; i++) vals[i] = 32'h0;
        do_reset();

        // Single request from r0: 1.0 -> 1.
        vals[0] = 32'h3F80_0000;
        in_cont = 4'b0001;
        run_txn(2'd0, 32'h3F80_0000, 32'h0000_0001, 0, 0);
        chk("single_idle_busy", 32'(busy), 32'h0);
        @(negedge clk);
        chk("single_idle_in_ready", 32'(in_ready), 32'h0);
        chk("single_idle_busy2", 32'(busy), 32'h0);

        // All four at once after reset: order 0,1,2,3.
        do_reset();
        vals[0] = 32'h4040_0000;
        vals[1] = 32'hBF80_0000;
        vals[2] = 32'hC020_0000;
        vals[3] = 32'h3F00_0000;
        in_cont = 4'b1111;
        run_txn(2'd0, 32'h4040_0000, 32'h0000_0003, 0, 0);
        run_txn(2'd1, 32'hBF80_0000, 32'hFFFF_FFFF, 0, 0);
        run_txn(2'd2, 32'hC020_0000, 32'hFFFF_FFFE, 0, 0);
        run_txn(2'd3, 32'h3F00_0000, 32'h0000_0000, 0, 0);

        // Fairness: serve r1 alone (ptr=1), then r0 and r3 together -> r3 first.
        vals[1] = 32'h40A0_0000;
        in_cont = 4'b0010;
        run_txn(2'd1, 32'h40A0_0000, 32'h0000_0005, 0, 0);
        vals[0] = 32'h4040_0000;
        vals[3] = 32'h3F80_0000;
        in_cont = 4'b1001;
        run_txn(2'd3, 32'h3F80_0000, 32'h0000_0001, 0, 0);
        run_txn(2'd0, 32'h4040_0000, 32'h0000_0003, 0, 0);

        // Backpressure on converter input and requester output, with r2 pending.
        vals[1] = 32'h42F6_0000;
        vals[2] = 32'h40A0_0000;
        in_cont = 4'b0110;
        run_txn(2'd1, 32'h42F6_0000, 32'h0000_007B, 10, 20);
        run_txn(2'd2, 32'h40A0_0000, 32'h0000_0005, 0, 0);

        // Withdrawal: r1 drops in ACCEPT; ptr stays 2, so r1 later beats r2.
        in_cont = 4'b0010;
        @(negedge clk);
        chk("withdraw_ready", 32'(in_ready), 32'h2);
        chk("withdraw_grant", 32'(grant), 32'h1);
        in_cont = 4'b0000;
        @(negedge clk);
        chk("withdraw_idle_ready", 32'(in_ready), 32'h0);
        chk("withdraw_idle_busy", 32'(busy), 32'h0);
        vals[1] = 32'h3F80_0000;
        vals[2] = 32'hBF80_0000;
        in_cont = 4'b0110;
        run_txn(2'd1, 32'h3F80_0000, 32'h0000_0001, 0, 0);
        run_txn(2'd2, 32'hBF80_0000, 32'hFFFF_FFFF, 0, 0);

        // Asynchronous reset while waiting on the converter.
        vals[1] = 32'h3F80_0000;
        in_cont = 4'b0010;
        wait_accept(2'd1);
        @(negedge clk);
        in_cont = 4'b0000;
        @(negedge clk);
        chk("pre_reset_wait_cont", 32'(cv_int_cont), 32'h1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        vals[0] = 32'h4F00_0000;
        vals[3] = 32'h3F80_0000;
        in_cont = 4'b1001;
        run_txn(2'd0, 32'h4F00_0000, 32'h8000_0000, 0, 0);
        run_txn(2'd3, 32'h3F80_0000, 32'h0000_0001, 0, 0);
        chk("final_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
